// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Parametrised inter-stage pipeline register with a valid/ready
//            handshake and a 2-entry skid buffer. The payload is split into a
//            control field, which is zeroed on flush or bubble, and a data
//            field, which is optionally kept on flush. Saturating stall,
//            bubble and flush counters support performance debug.
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready/in_ctrl/in_data    - upstream handshake
//            flush                                - synchronous squash
//            out_valid/out_ready/out_ctrl/out_data - downstream handshake
//            stall_cnt/bubble_cnt/flush_cnt       - performance counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int CTRL_W          = 16,
  parameter int DATA_W          = 160,
  parameter int FLUSH_KEEP_DATA = 1,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t            r_state;
  state_t            w_state_next;

  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_accept;
  logic              w_drain;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid_in;

  // Both handshake outputs decode straight from the state register, so
  // in_ready never depends combinationally on out_ready.
  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = out_valid & out_ready;

  // A bubble must look like a NOP downstream, whatever main still holds.
  assign out_ctrl  = out_valid ? r_main_ctrl : '0;
  assign out_data  = r_main_data;

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;

  // --------------------------------------------------------------------------
  // Next-state and load-enable decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid_in   = 1'b0;
    if (flush) begin
      // Squash wins over any handshake; the input of this cycle is dropped.
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next   = ST_ONE;
            w_load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_state_next   = ST_TWO;
            w_load_skid_in = 1'b1;
          end else if (w_drain) begin
            w_state_next   = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            w_state_next     = ST_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Payload storage: entries not being loaded keep their contents bit-exact.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      if (FLUSH_KEEP_DATA == 0) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else begin
      if (w_load_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid_in) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters (cleared only by reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
      if (!out_valid && out_ready && (r_bubble_cnt != c_cnt_max)) begin
        r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
      end
      if (flush && (r_flush_cnt != c_cnt_max)) begin
        r_flush_cnt <= r_flush_cnt + c_cnt_one;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed self-checking bench for pipe_stage_reg. Two instances
//            share all stimulus: u_dut_keep (FLUSH_KEEP_DATA=1, CNT_W=16) and
//            u_dut_zero (FLUSH_KEEP_DATA=0, CNT_W=4), so flush data handling
//            and counter saturation are both observable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 160;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_ready;

  logic              k_in_ready, k_out_valid;
  logic [CTRL_W-1:0] k_out_ctrl;
  logic [DATA_W-1:0] k_out_data;
  logic [15:0]       k_stall, k_bubble, k_flush;

  logic              z_in_ready, z_out_valid;
  logic [CTRL_W-1:0] z_out_ctrl;
  logic [DATA_W-1:0] z_out_data;
  logic [3:0]        z_stall, z_bubble, z_flush;

  int                n_tests;
  int                n_fail;

  pipe_stage_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .FLUSH_KEEP_DATA(1), .CNT_W(16)
  ) u_dut_keep (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(k_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(k_out_valid), .out_ready(out_ready),
    .out_ctrl(k_out_ctrl), .out_data(k_out_data),
    .stall_cnt(k_stall), .bubble_cnt(k_bubble), .flush_cnt(k_flush)
  );

  pipe_stage_reg #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .FLUSH_KEEP_DATA(0), .CNT_W(4)
  ) u_dut_zero (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(z_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(z_out_valid), .out_ready(out_ready),
    .out_ctrl(z_out_ctrl), .out_data(z_out_data),
    .stall_cnt(z_stall), .bubble_cnt(z_bubble), .flush_cnt(z_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Data payload derived from the control tag so every entry is distinct.
  function automatic logic [DATA_W-1:0] dat(input logic [15:0] c);
    return {10{c ^ 16'hA5C3}};
  endfunction

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic rdy);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = dat(c);
    out_ready = rdy;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    drive(1'b0, 16'h0, 1'b0);

    // ---------------- Reset state ----------------
    #1;
    check("rst_out_valid", DATA_W'(k_out_valid), '0);
    check("rst_in_ready",  DATA_W'(k_in_ready), DATA_W'(1));
    check("rst_out_ctrl",  DATA_W'(k_out_ctrl), '0);
    check("rst_out_data",  k_out_data, '0);
    check("rst_counters",  DATA_W'({k_stall, k_bubble, k_flush}), '0);
    tick();
    tick();
    reset = 1'b0;

    // ---------------- 1: streaming, out_ready=1 ----------------
    drive(1'b1, 16'h0011, 1'b1);
    check("s1_pre_valid", DATA_W'(k_out_valid), '0);
    tick();
    check("s1_first_valid", DATA_W'(k_out_valid), DATA_W'(1));
    check("s1_ctrl_11", DATA_W'(k_out_ctrl), DATA_W'(16'h0011));
    check("s1_data_11", k_out_data, dat(16'h0011));
    for (int i = 2; i <= 4; i++) begin
      drive(1'b1, 16'h0010 + 16'(i), 1'b1);
      tick();
      check("s1_ctrl_seq", DATA_W'(k_out_ctrl), DATA_W'(16'h0010 + 16'(i)));
      check("s1_in_ready", DATA_W'(k_in_ready), DATA_W'(1));
    end
    drive(1'b0, 16'h0, 1'b1);
    tick();
    check("s1_drained", DATA_W'(k_out_valid), '0);
    check("s1_stall_cnt", DATA_W'(k_stall), '0);

    // ---------------- 2: stall and skid fill ----------------
    drive(1'b1, 16'h0021, 1'b0);          // A enters EMPTY
    tick();
    drive(1'b1, 16'h0022, 1'b0);          // B into skid
    tick();
    check("s2_in_ready_two", DATA_W'(k_in_ready), '0);
    check("s2_ctrl_A_1", DATA_W'(k_out_ctrl), DATA_W'(16'h0021));
    drive(1'b1, 16'h0023, 1'b0);          // C offered, must be held upstream
    tick();
    check("s2_ctrl_A_2", DATA_W'(k_out_ctrl), DATA_W'(16'h0021));
    tick();
    check("s2_ctrl_A_3", DATA_W'(k_out_ctrl), DATA_W'(16'h0021));
    check("s2_data_A", k_out_data, dat(16'h0021));
    check("s2_stall_cnt", DATA_W'(k_stall), DATA_W'(3));
    out_ready = 1'b1;
    tick();
    check("s2_ctrl_B", DATA_W'(k_out_ctrl), DATA_W'(16'h0022));
    check("s2_in_ready_one", DATA_W'(k_in_ready), DATA_W'(1));
    tick();
    check("s2_ctrl_C", DATA_W'(k_out_ctrl), DATA_W'(16'h0023));
    check("s2_data_C", k_out_data, dat(16'h0023));
    drive(1'b0, 16'h0, 1'b1);
    tick();
    check("s2_empty", DATA_W'(k_out_valid), '0);

    // ---------------- 3/4: flush in TWO with in_valid=1 ----------------
    drive(1'b1, 16'h0031, 1'b0);
    tick();
    drive(1'b1, 16'h0032, 1'b0);
    tick();
    check("s3_in_two", DATA_W'(k_in_ready), '0);
    drive(1'b1, 16'h0033, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("s3_valid", DATA_W'(k_out_valid), '0);
    check("s3_ctrl", DATA_W'(k_out_ctrl), '0);
    check("s3_data_kept", k_out_data, dat(16'h0031));
    check("s3_in_ready", DATA_W'(k_in_ready), DATA_W'(1));
    check("s3_flush_cnt", DATA_W'(k_flush), DATA_W'(1));
    check("s4_valid", DATA_W'(z_out_valid), '0);
    check("s4_data_zero", z_out_data, '0);
    check("s4_flush_cnt", DATA_W'(z_flush), DATA_W'(1));
    drive(1'b0, 16'h0, 1'b1);
    tick();
    check("s3_dropped", DATA_W'(k_out_valid), '0);
    check("s3_data_hold", k_out_data, dat(16'h0031));

    // ---------------- 5: async reset mid-cycle in TWO ----------------
    drive(1'b1, 16'h0051, 1'b0);
    tick();
    drive(1'b1, 16'h0052, 1'b0);
    tick();
    check("s5_in_two", DATA_W'(k_in_ready), '0);
    drive(1'b0, 16'h0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("s5_valid", DATA_W'(k_out_valid), '0);
    check("s5_in_ready", DATA_W'(k_in_ready), DATA_W'(1));
    check("s5_ctrl", DATA_W'(k_out_ctrl), '0);
    check("s5_data", k_out_data, '0);
    check("s5_counters", DATA_W'({k_stall, k_bubble, k_flush}), '0);
    tick();
    reset = 1'b0;

    // ---------------- 6: bubble counter saturation ----------------
    drive(1'b0, 16'h0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) begin
        check("s6_bubble_at15", DATA_W'(z_bubble), DATA_W'(15));
      end
    end
    check("s6_bubble_sat", DATA_W'(z_bubble), DATA_W'(15));
    check("s6_bubble_wide", DATA_W'(k_bubble), DATA_W'(20));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
